// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB writeback stage: result packet and the reserved null tag.
package cdb_arbiter_pkg;

  localparam int unsigned BITWIDTH = 32;

  typedef struct packed {
    logic [BITWIDTH-1:0] tag;
    logic [BITWIDTH-1:0] data;
  } cdb_packet_t;

  // RS entry IDs start at 1, so tag 0 never names a real producer.
  localparam logic [BITWIDTH-1:0] CDB_NO_TAG = '0;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: small circular FIFO of CDB packets with synchronous flush.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  cdb_packet_t push_pkt,
  output logic        full,
  output logic        empty,
  output cdb_packet_t head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  cdb_packet_t     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_pkt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter over per-FU result buffers, registered CDB outputs.
// Define CDB_BYPASS_EN to let a beat arriving at an empty buffer compete in its arrival cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned SrcW      = $clog2(N_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           flush,
  input  logic [N_SRC-1:0]               src_valid,
  input  logic [N_SRC-1:0][BITWIDTH-1:0] src_tag,
  input  logic [N_SRC-1:0][BITWIDTH-1:0] src_data,
  output logic [N_SRC-1:0]               src_ready,
  output logic                           cdb_valid,
  output logic [BITWIDTH-1:0]            cdb_tag,
  output logic [BITWIDTH-1:0]            cdb_data,
  output logic [SrcW-1:0]                cdb_src
);

  logic [N_SRC-1:0]        full, empty, push, cand, fifo_push, fifo_pop;
  cdb_packet_t [N_SRC-1:0] head, in_pkt;
  cdb_packet_t             win_pkt;
  logic [SrcW-1:0]         rr_ptr_q, rr_ptr_d, win;
  logic                    grant, bypass_hit;
  logic                    cdb_valid_q;
  logic [BITWIDTH-1:0]     cdb_tag_q, cdb_data_q;
  logic [SrcW-1:0]         cdb_src_q;

  function automatic logic [SrcW-1:0] wrap_add(input logic [SrcW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_SRC) s = s - N_SRC;
    return SrcW'(s);
  endfunction

  always_comb begin
    grant = 1'b0;
    win   = rr_ptr_q;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_ready[i]  = en & ~flush & ~full[i] & ~rst;
      push[i]       = src_valid[i] & src_ready[i];
      in_pkt[i].tag  = src_tag[i];
      in_pkt[i].data = src_data[i];
`ifdef CDB_BYPASS_EN
      cand[i] = ~empty[i] | push[i];
`else
      cand[i] = ~empty[i];
`endif
    end
    // First candidate at or after rr_ptr wins, wrapping around.
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!grant && cand[wrap_add(rr_ptr_q, k)]) begin
        grant = 1'b1;
        win   = wrap_add(rr_ptr_q, k);
      end
    end
    grant      = grant & en & ~flush;
    // Only reachable with bypass: a granted candidate that is still empty is this cycle's beat.
    bypass_hit = grant & empty[win];
    win_pkt    = bypass_hit ? in_pkt[win] : head[win];
    for (int unsigned i = 0; i < N_SRC; i++) begin
      fifo_pop[i]  = grant & (win == SrcW'(i)) & ~empty[i];
      fifo_push[i] = push[i] & ~(bypass_hit & (win == SrcW'(i)));
    end
    rr_ptr_d = grant ? wrap_add(win, 1) : rr_ptr_q;
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
    cdb_src_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push[g]),
      .pop     (fifo_pop[g]),
      .flush   (flush),
      .push_pkt(in_pkt[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .head    (head[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= CDB_NO_TAG;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= grant;
      if (grant) begin
        cdb_tag_q  <= win_pkt.tag;
        cdb_data_q <= win_pkt.data;
        cdb_src_q  <= win;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expectations follow the CDB_BYPASS_EN build.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned N = 4;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                    clk = 1'b0;
  logic                    rst, en, flush;
  logic [N-1:0]            src_valid, src_ready;
  logic [N-1:0][31:0]      src_tag, src_data;
  logic                    cdb_valid;
  logic [31:0]             cdb_tag, cdb_data;
  logic [1:0]              cdb_src;
  int                      errors = 0;
  int                      checks = 0;
  bit                      mon_on = 1'b0;
  logic [33:0]             got[$];

  cdb_arbiter #(
    .N_SRC     (N),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .src_valid(src_valid),
    .src_tag  (src_tag),
    .src_data (src_data),
    .src_ready(src_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_on && cdb_valid === 1'b1) got.push_back({cdb_src, cdb_tag});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_all(input logic [31:0] base);
    for (int i = 0; i < N; i++) begin
      src_valid[i] = 1'b1;
      src_tag[i]   = base + i;
      src_data[i]  = base + 32'h1000 + i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); src_valid = '1;
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 32'h0) begin errors++; $display("FAIL rst_tag: got %h want 0", cdb_tag); end
    checks++; if (cdb_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", cdb_data); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL rst_src: got %0d want 0", cdb_src); end
    checks++; if (src_ready !== 4'h0) begin errors++; $display("FAIL rst_ready: got %b want 0000", src_ready); end
    rst = 1'b0; src_valid = '0;
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got %b want 0", cdb_valid); end
  endtask

  task automatic test_single();
    do_reset();
    src_valid[0] = 1'b1; src_tag[0] = 32'h0001_0003; src_data[0] = 32'hDEAD_BEEF;
    #1;
    checks++; if (src_ready !== 4'hF) begin errors++; $display("FAIL single_ready: got %b want 1111", src_ready); end
    step();
    src_valid = '0;
    repeat (LAT - 1) step();
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
    checks++; if (cdb_tag !== 32'h0001_0003) begin errors++; $display("FAIL single_tag: got %h want 00010003", cdb_tag); end
    checks++; if (cdb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", cdb_data); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL single_src: got %0d want 0", cdb_src); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 32'h0001_0003) begin errors++; $display("FAIL single_hold: got %h want 00010003", cdb_tag); end
  endtask

  task automatic test_all_sources();
    do_reset();
    load_all(32'h10);
    step();
    src_valid = '0;
    repeat (LAT - 1) step();
    for (int i = 0; i < N; i++) begin
      checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL all_valid[%0d]: got %b want 1", i, cdb_valid); end
      checks++; if (cdb_src !== 2'(i)) begin errors++; $display("FAIL all_src[%0d]: got %0d want %0d", i, cdb_src, i); end
      checks++; if (cdb_tag !== 32'h10 + i) begin errors++; $display("FAIL all_tag[%0d]: got %h want %h", i, cdb_tag, 32'h10 + i); end
      step();
    end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL all_idle: got %b want 0", cdb_valid); end
    // rr_ptr must be back at 0: src0 beats src3 when both arrive together.
    src_valid = 4'b1001; src_tag[0] = 32'h20; src_tag[3] = 32'h23;
    step();
    src_valid = '0;
    repeat (LAT - 1) step();
    checks++; if (cdb_src !== 2'd0 || cdb_tag !== 32'h20) begin errors++; $display("FAIL rr_wrap_first: got src %0d tag %h want src 0 tag 20", cdb_src, cdb_tag); end
    step();
    checks++; if (cdb_src !== 2'd3 || cdb_tag !== 32'h23) begin errors++; $display("FAIL rr_wrap_second: got src %0d tag %h want src 3 tag 23", cdb_src, cdb_tag); end
  endtask

  task automatic test_back_to_back();
    int n[3];
    int cyc;
    int cnt;
    logic [N-1:0] acc;
    do_reset();
    got.delete();
    mon_on = 1'b1;
    n = '{0, 0, 0};
    cyc = 0;
    while ((n[0] < 2 || n[1] < 2 || n[2] < 3) && cyc < 20) begin
      for (int s = 0; s < 3; s++) begin
        src_valid[s] = (n[s] < ((s == 2) ? 3 : 2));
        src_tag[s]   = 32'h100 * (s + 1) + n[s];
        src_data[s]  = 32'hD000 + 32'h100 * (s + 1) + n[s];
      end
      #1;
      if (cyc == 2) begin
        checks++; if (src_ready[2] !== 1'b0) begin errors++; $display("FAIL b2b_ready2_full: got %b want 0", src_ready[2]); end
      end
      acc = src_valid & src_ready;
      step();
      for (int s = 0; s < 3; s++) if (acc[s]) n[s]++;
      cyc++;
    end
    src_valid = '0;
    checks++; if (n[2] != 3) begin errors++; $display("FAIL b2b_accept: got %0d src2 beats accepted want 3", n[2]); end
    repeat (12) step();
    mon_on = 1'b0;
    checks++; if (got.size() != 7) begin errors++; $display("FAIL b2b_count: got %0d broadcasts want 7", got.size()); end
    for (int s = 0; s < 3; s++) begin
      cnt = 0;
      for (int k = 0; k < got.size(); k++) begin
        if (got[k][33:32] == 2'(s)) begin
          checks++;
          if (got[k][31:0] !== 32'h100 * (s + 1) + cnt) begin
            errors++;
            $display("FAIL b2b_order src%0d[%0d]: got %h want %h", s, cnt, got[k][31:0], 32'h100 * (s + 1) + cnt);
          end
          cnt++;
        end
      end
      checks++; if (cnt != ((s == 2) ? 3 : 2)) begin errors++; $display("FAIL b2b_src%0d_count: got %0d", s, cnt); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    load_all(32'h400);
    step();
    src_valid = '0;
    flush = 1'b1;
    #1;
    checks++; if (src_ready !== 4'h0) begin errors++; $display("FAIL flush_ready_low: got %b want 0000", src_ready); end
    step();
    flush = 1'b0;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", cdb_valid); end
    #1;
    checks++; if (src_ready !== 4'hF) begin errors++; $display("FAIL flush_ready_back: got %b want 1111", src_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_stale[%0d]: got valid %b tag %h want 0", c, cdb_valid, cdb_tag); end
    end
  endtask

  task automatic test_enable();
    int exp_seq[$];
`ifdef CDB_BYPASS_EN
    exp_seq = '{3, 0, 1};
`else
    exp_seq = '{2, 3, 0, 1};
`endif
    do_reset();
    // One beat from src1 leaves rr_ptr at 2.
    src_valid[1] = 1'b1; src_tag[1] = 32'h501;
    step();
    src_valid = '0;
    repeat (LAT) step();
    load_all(32'h600);
    step();
    src_valid = '0;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL en_hold_valid[%0d]: got %b want 0", c, cdb_valid); end
      checks++; if (src_ready !== 4'h0) begin errors++; $display("FAIL en_hold_ready[%0d]: got %b want 0000", c, src_ready); end
    end
    en = 1'b1;
    foreach (exp_seq[k]) begin
      step();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'(exp_seq[k]) || cdb_tag !== 32'h600 + exp_seq[k]) begin
        errors++;
        $display("FAIL en_resume[%0d]: got v %b src %0d tag %h want v 1 src %0d tag %h",
                 k, cdb_valid, cdb_src, cdb_tag, exp_seq[k], 32'h600 + exp_seq[k]);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    load_all(32'h700);
    step();
    src_valid = '0;
    step();
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b want 1", cdb_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 32'h0 || cdb_data !== 32'h0) begin errors++; $display("FAIL rmid_payload: got %h/%h want 0/0", cdb_tag, cdb_data); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL rmid_src: got %0d want 0", cdb_src); end
    checks++; if (src_ready !== 4'h0) begin errors++; $display("FAIL rmid_ready: got %b want 0000", src_ready); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rmid_first: got %b want 0", cdb_valid); end
    checks++; if (src_ready !== 4'hF) begin errors++; $display("FAIL rmid_ready_back: got %b want 1111", src_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rmid_empty[%0d]: got %b want 0", c, cdb_valid); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_all_sources();
    test_back_to_back();
    test_flush();
    test_enable();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
